// File: rtl/rst_seq_hme.sv
// Staged reset sequencer: qualifies an asynchronous PLL lock, holds every reset
// output for a fixed time, then releases the outputs one stage at a time.
// Lock loss drops the whole sequence back to lock qualification, and a software
// request restarts it from the hold phase.
module rst_seq_hme #(
    parameter int unsigned N_STAGES  = 3,
    parameter int unsigned LOCK_FILT = 4,
    parameter int unsigned HOLD_CYC  = 16,
    parameter int unsigned GAP_CYC   = 8
) (
    input  logic                C,
    input  logic                R,
    input  logic                LOCKED,
    input  logic                SW_REQ,
    output logic [N_STAGES-1:0] RST_OUT,
    output logic                DONE,
    output logic                BUSY
);

    // Each counter is just wide enough to hold its parameter value.
    localparam int unsigned FW = $clog2(LOCK_FILT + 1);
    localparam int unsigned HW = $clog2(HOLD_CYC + 1);
    localparam int unsigned GW = $clog2(GAP_CYC + 1);
    localparam int unsigned IW = $clog2(N_STAGES + 1);

    localparam logic [FW-1:0] FILT_MAX  = FW'(LOCK_FILT);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYC);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_STAGES - 1);

    typedef enum logic [1:0] {
        StWaitLock,
        StHold,
        StRelease,
        StRun
    } state_e;

    // Declaration initialisers give the same power-up state as reset.
    logic                sync1_q = 1'b0;
    logic                sync2_q = 1'b0;
    state_e              state_q = StWaitLock;
    state_e              state_d;
    logic [FW-1:0]       filt_q  = '0;
    logic [FW-1:0]       filt_d;
    logic [HW-1:0]       hold_q  = '0;
    logic [HW-1:0]       hold_d;
    logic [GW-1:0]       gap_q   = '0;
    logic [GW-1:0]       gap_d;
    logic [IW-1:0]       idx_q   = '0;
    logic [IW-1:0]       idx_d;
    logic [IW-1:0]       idx_inc;
    logic [N_STAGES-1:0] rst_q   = '1;
    logic [N_STAGES-1:0] rst_d;
    logic                done_q  = 1'b0;
    logic                done_d;
    logic                busy_q  = 1'b1;
    logic                busy_d;
    logic                lock_s;

    // Reset pattern while stages 0..idx are released: bit i stays high iff i > idx.
    function automatic logic [N_STAGES-1:0] stage_mask(input logic [IW-1:0] idx);
        logic [N_STAGES-1:0] m;
        for (int unsigned i = 0; i < N_STAGES; i++) begin
            m[i] = (i > 32'(idx));
        end
        return m;
    endfunction

    assign lock_s  = sync2_q;
    assign idx_inc = idx_q + 1'b1;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge C) begin
        if (R) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= LOCKED;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        rst_d   = rst_q;

        if (state_q != StWaitLock && !lock_s) begin
            // Lock loss outranks everything, including a software request.
            state_d = StWaitLock;
            filt_d  = '0;
            hold_d  = '0;
            gap_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    rst_d  = '1;
                    hold_d = '0;
                    gap_d  = '0;
                    idx_d  = '0;
                    if (!lock_s) begin
                        filt_d = '0;
                    end else begin
                        if (filt_q != FILT_MAX) begin
                            filt_d = filt_q + 1'b1;
                        end
                        if (filt_q >= FILT_LAST) begin
                            state_d = StHold;
                        end
                    end
                end

                StHold: begin
                    rst_d = '1;
                    gap_d = '0;
                    idx_d = '0;
                    if (SW_REQ) begin
                        hold_d = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        // Stage 0 drops on the very first RELEASE cycle.
                        state_d = StRelease;
                        hold_d  = '0;
                        rst_d   = stage_mask('0);
                    end else if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                end

                StRelease: begin
                    if (SW_REQ) begin
                        state_d = StHold;
                        hold_d  = '0;
                        gap_d   = '0;
                        idx_d   = '0;
                        rst_d   = '1;
                    end else if (idx_q == IDX_LAST) begin
                        // Only reachable with a single stage: one RELEASE cycle, then RUN.
                        state_d = StRun;
                        rst_d   = '0;
                    end else if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        idx_d = idx_inc;
                        rst_d = stage_mask(idx_inc);
                        if (idx_inc == IDX_LAST) begin
                            state_d = StRun;
                        end
                    end else if (gap_q != GAP_MAX) begin
                        gap_d = gap_q + 1'b1;
                    end
                end

                StRun: begin
                    rst_d = '0;
                    if (SW_REQ) begin
                        // Lock stays qualified, so go straight back to HOLD.
                        state_d = StHold;
                        hold_d  = '0;
                        gap_d   = '0;
                        idx_d   = '0;
                        rst_d   = '1;
                    end
                end
            endcase
        end

        done_d = (state_d == StRun);
        busy_d = (state_d != StRun);
    end

    // State, counters and outputs, all registered so nothing downstream sees a glitch.
    always_ff @(posedge C) begin
        if (R) begin
            state_q <= StWaitLock;
            filt_q  <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign RST_OUT = rst_q;
    assign DONE    = done_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_rst_seq_hme.sv
// Bench for rst_seq_hme: directed scenarios followed by random lock/request/reset
// traffic, all compared every cycle against an elapsed-time reference model.
module tb_rst_seq_hme;

    localparam int unsigned N  = 3;
    localparam int unsigned LF = 4;
    localparam int unsigned HC = 16;
    localparam int unsigned GC = 8;

    localparam int M_WAIT = 0;
    localparam int M_HOLD = 1;
    localparam int M_REL  = 2;
    localparam int M_RUN  = 3;

    logic         C      = 1'b0;
    logic         R      = 1'b1;
    logic         LOCKED = 1'b0;
    logic         SW_REQ = 1'b0;
    logic [N-1:0] RST_OUT;
    logic         DONE;
    logic         BUSY;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase plus elapsed cycles in that phase.
    int   mode    = M_WAIT;
    int   run_len = 0;
    int   t_hold  = 0;
    int   t_rel   = 0;
    logic s1      = 1'b0;
    logic s2      = 1'b0;

    rst_seq_hme #(
        .N_STAGES (N),
        .LOCK_FILT(LF),
        .HOLD_CYC (HC),
        .GAP_CYC  (GC)
    ) dut (
        .C      (C),
        .R      (R),
        .LOCKED (LOCKED),
        .SW_REQ (SW_REQ),
        .RST_OUT(RST_OUT),
        .DONE   (DONE),
        .BUSY   (BUSY)
    );

    always #5 C = ~C;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Advance the model across one rising edge given the inputs seen at that edge.
    task automatic model_step(input logic r, input logic lk, input logic sw);
        logic lock_s;
        if (r) begin
            mode    = M_WAIT;
            run_len = 0;
            t_hold  = 0;
            t_rel   = 0;
            s1      = 1'b0;
            s2      = 1'b0;
        end else begin
            lock_s = s2;
            if (mode != M_WAIT && !lock_s) begin
                mode    = M_WAIT;
                run_len = 0;
            end else begin
                case (mode)
                    M_WAIT: begin
                        run_len = lock_s ? run_len + 1 : 0;
                        if (run_len >= LF) begin
                            mode   = M_HOLD;
                            t_hold = 0;
                        end
                    end
                    M_HOLD: begin
                        if (sw) t_hold = 0;
                        else begin
                            t_hold++;
                            if (t_hold == HC) begin
                                mode  = M_REL;
                                t_rel = 0;
                            end
                        end
                    end
                    M_REL: begin
                        if (sw) begin
                            mode   = M_HOLD;
                            t_hold = 0;
                        end else begin
                            t_rel++;
                            if (1 + t_rel / GC >= N) mode = M_RUN;
                        end
                    end
                    default: begin
                        if (sw) begin
                            mode   = M_HOLD;
                            t_hold = 0;
                        end
                    end
                endcase
            end
            s2 = s1;
            s1 = lk;
        end
    endtask

    function automatic logic [N-1:0] exp_rst();
        logic [N-1:0] e = '1;
        int rel;
        if (mode == M_RUN) rel = N;
        else if (mode == M_REL) rel = 1 + t_rel / GC;
        else rel = 0;
        for (int i = 0; i < N; i++) begin
            if (i < rel) e[i] = 1'b0;
        end
        return e;
    endfunction

    task automatic cycle(input logic r, input logic lk, input logic sw, input string tag);
        @(negedge C);
        R      = r;
        LOCKED = lk;
        SW_REQ = sw;
        @(posedge C);
        model_step(r, lk, sw);
        #1;
        check({tag, "_rst"}, 32'(RST_OUT), 32'(exp_rst()));
        check({tag, "_done"}, 32'(DONE), 32'(mode == M_RUN));
        check({tag, "_busy"}, 32'(BUSY), 32'(mode != M_RUN));
    endtask

    initial begin
        logic lk;
        logic sw;
        logic r;

        #1;
        check("pwrup_rst", 32'(RST_OUT), 32'h7);
        check("pwrup_done", 32'(DONE), 32'h0);
        check("pwrup_busy", 32'(BUSY), 32'h1);

        // Nominal bring-up with lock held high.
        repeat (2) cycle(1'b1, 1'b1, 1'b0, "por");
        for (int k = 1; k <= 45; k++) begin
            cycle(1'b0, 1'b1, 1'b0, "boot");
            if (k == 21) check("boot_hold_end", 32'(RST_OUT), 32'h7);
            if (k == 22) check("boot_bit0", 32'(RST_OUT), 32'h6);
            if (k == 29) check("boot_pre_bit1", 32'(RST_OUT), 32'h6);
            if (k == 30) check("boot_bit1", 32'(RST_OUT), 32'h4);
            if (k == 37) check("boot_pre_done", 32'(DONE), 32'h0);
            if (k == 38) check("boot_bit2", 32'(RST_OUT), 32'h0);
            if (k == 38) check("boot_done", 32'(DONE), 32'h1);
        end

        // Short lock glitch must not qualify; filter restarts on the real lock.
        repeat (2) cycle(1'b1, 1'b0, 1'b0, "glr");
        repeat (3) cycle(1'b0, 1'b1, 1'b0, "glhi");
        repeat (6) cycle(1'b0, 1'b0, 1'b0, "gllo");
        for (int k = 1; k <= 45; k++) begin
            cycle(1'b0, 1'b1, 1'b0, "glok");
            if (k == 21) check("glitch_hold", 32'(RST_OUT), 32'h7);
            if (k == 38) check("glitch_done", 32'(DONE), 32'h1);
        end

        // Lock loss in RUN, then re-lock.
        cycle(1'b0, 1'b0, 1'b0, "ldrop");
        cycle(1'b0, 1'b1, 1'b0, "ldrop1");
        cycle(1'b0, 1'b1, 1'b0, "ldrop2");
        check("lossrun_rst", 32'(RST_OUT), 32'h7);
        check("lossrun_done", 32'(DONE), 32'h0);
        for (int k = 1; k <= 45; k++) cycle(1'b0, 1'b1, 1'b0, "relock");
        check("relock_done", 32'(DONE), 32'h1);

        // Software request in RUN: HOLD then release, no refiltering.
        cycle(1'b0, 1'b1, 1'b1, "swrun");
        check("swrun_rst", 32'(RST_OUT), 32'h7);
        for (int k = 1; k <= 24; k++) begin
            cycle(1'b0, 1'b1, 1'b0, "swseq");
            if (k == 15) check("swseq_hold", 32'(RST_OUT), 32'h7);
            if (k == 16) check("swseq_bit0", 32'(RST_OUT), 32'h6);
        end

        // Lock loss and SW_REQ coincide in RELEASE: lock loss wins.
        cycle(1'b0, 1'b0, 1'b0, "coinc0");
        cycle(1'b0, 1'b1, 1'b0, "coinc1");
        cycle(1'b0, 1'b1, 1'b1, "coinc2");
        check("coinc_busy", 32'(BUSY), 32'h1);
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b0, 1'b1, 1'b0, "coincrun");
            if (k == 16) check("coinc_no_hold", 32'(RST_OUT), 32'h7);
            if (k == 20) check("coinc_bit0", 32'(RST_OUT), 32'h6);
        end

        // R mid-RELEASE.
        cycle(1'b0, 1'b1, 1'b1, "rrel_sw");
        repeat (17) cycle(1'b0, 1'b1, 1'b0, "rrel");
        check("rrel_pre", 32'(RST_OUT), 32'h6);
        cycle(1'b1, 1'b1, 1'b0, "rrel_r");
        check("rrel_rst", 32'(RST_OUT), 32'h7);
        check("rrel_done", 32'(DONE), 32'h0);
        check("rrel_busy", 32'(BUSY), 32'h1);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, "rrel_after");

        // Random lock drops, software requests and resets.
        lk = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (lk) begin
                if ($urandom_range(0, 199) < 2) lk = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                lk = 1'b1;
            end
            sw = ($urandom_range(0, 59) == 0);
            r  = ($urandom_range(0, 499) == 0);
            cycle(r, lk, sw, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
